muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the same forwarded operand pair as the ALU. Its result is muxed with ALUout ahead of the EX/MEM register. The hazard unit stalls the pipeline while busy is high.

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// muldiv_unit_if : request/response bundle between the EX stage and muldiv_unit
// Rev 1.0
// ============================================================================
interface muldiv_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  start;
  logic                  flush;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, flush, funct3, op1, op2,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op1, op2,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative RV32M multiply/divide (shift-add / restoring divide)
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
// Rev 1.0
// ============================================================================
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int            W        = DATA_WIDTH;
  localparam int            CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   result_q;
  logic [2:0]     op_q;
  logic           neg_q;
  logic           neg_rem_q;
  logic [CW-1:0]  cnt_q;
  // Multiply: acc += mcand when mplier LSB set. Divide: acc = {rem, dividend/quotient}, mplier = divisor.
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;

  // Decode of the request presented on the bus
  logic         is_div;
  logic         sgn1;
  logic         sgn2;
  logic         neg1;
  logic         neg2;
  logic [W-1:0] mag1;
  logic [W-1:0] mag2;
  logic         accept;
  logic         div_zero;
  logic         div_ovf;
  logic [W-1:0] special_res;
  logic         fast_hit;
  logic [W-1:0] fast_res;

  assign is_div   = bus.funct3[2];
  assign sgn1     = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign sgn2     = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
  assign neg1     = sgn1 & bus.op1[W-1];
  assign neg2     = sgn2 & bus.op2[W-1];
  assign mag1     = neg1 ? -bus.op1 : bus.op1;
  assign mag2     = neg2 ? -bus.op2 : bus.op2;
  assign accept   = bus.start & ~bus.flush & (state_q != S_RUN);
  assign div_zero = is_div & (bus.op2 == '0);
  assign div_ovf  = is_div & ~bus.funct3[0]
                  & (bus.op1 == {1'b1, {(W-1){1'b0}}}) & (&bus.op2);
  assign special_res = div_zero ? (bus.funct3[1] ? bus.op1 : '1)
                                : (bus.funct3[1] ? '0 : bus.op1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fast_mag;
  logic [2*W-1:0] fast_prod;
  assign fast_mag  = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
  assign fast_prod = (neg1 ^ neg2) ? -fast_mag : fast_mag;
  assign fast_res  = (bus.funct3[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
  assign fast_hit  = ~is_div;
`else
  assign fast_res  = '0;
  assign fast_hit  = 1'b0;
`endif

  // One iteration of either datapath, plus the sign fix-up used on the final one
  logic [2*W-1:0] mul_acc_d;
  logic [2*W-1:0] div_acc_d;
  logic [2*W-1:0] acc_d;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] prod_d;
  logic [W-1:0]   quo_d;
  logic [W-1:0]   rem_d;
  logic [W-1:0]   result_d;

  assign mul_acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff  = div_shift - {1'b0, mplier_q};
  assign div_ge    = ~div_diff[W];
  assign div_acc_d = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
  assign acc_d     = op_q[2] ? div_acc_d : mul_acc_d;

  assign prod_d = neg_q ? -mul_acc_d : mul_acc_d;
  assign quo_d  = neg_q ? -div_acc_d[W-1:0] : div_acc_d[W-1:0];
  assign rem_d  = neg_rem_q ? -div_acc_d[2*W-1:W] : div_acc_d[2*W-1:W];
  assign result_d = op_q[2] ? (op_q[1] ? rem_d : quo_d)
                            : ((op_q[1:0] == 2'b00) ? prod_d[W-1:0] : prod_d[2*W-1:W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_q << 1;
            cnt_q   <= cnt_q + 1'b1;
            if (!op_q[2]) begin
              mplier_q <= mplier_q >> 1;
            end
            if (cnt_q == LAST_CNT) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= result_d;
            end
          end
        end
        default: begin
          if (accept) begin
            op_q      <= bus.funct3;
            neg_q     <= neg1 ^ neg2;
            neg_rem_q <= neg1;
            cnt_q     <= '0;
            if (div_zero || div_ovf || fast_hit) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= (div_zero || div_ovf) ? special_res : fast_res;
            end else begin
              state_q  <= S_RUN;
              busy_q   <= 1'b1;
              mplier_q <= mag2;
              if (is_div) begin
                acc_q   <= {{W{1'b0}}, mag1};
                mcand_q <= '0;
              end else begin
                acc_q   <= '0;
                mcand_q <= {{W{1'b0}}, mag1};
              end
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed + random checks of muldiv_unit against an
// arithmetic reference model. Honours MULDIV_FAST_MUL_EN. Rev 1.0
// ============================================================================
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  muldiv_unit_if #(.DATA_WIDTH(32)) bus ();
  muldiv_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] ua;
    logic [63:0] ub;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // launched: inputs set by caller in the current (negedge) cycle; keep: return in the done cycle
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit launched, input bit keep, input bit poke);
    logic [31:0] exp;
    logic [31:0] prev;
    int          lat;
    int          busy_cnt;
    int          done_at;
    bit          stable;
    exp = ref_model(f3, a, b);
    lat = exp_lat(f3, a, b);
    if (!launched) @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b0; bus.funct3 = f3; bus.op1 = a; bus.op2 = b;
    prev = bus.result;
    @(posedge clk);
    busy_cnt = 0; done_at = 0; stable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0; bus.op1 = $urandom; bus.op2 = $urandom; bus.funct3 = 3'($urandom);
      end
      if (poke && k == 5) begin
        bus.start = 1'b1; bus.op1 = $urandom; bus.op2 = $urandom;
      end else if (poke && k == 6) begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_at = k;
        break;
      end
      if (bus.result !== prev) stable = 1'b0;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(done_at), 32'(lat));
    check({tag, " result"}, bus.result, exp);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check({tag, " result held"}, 32'(stable), 32'd1);
    check({tag, " busy in done"}, 32'(bus.busy), 32'd0);
    if (!keep) begin
      @(negedge clk);
      check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    bit          seen_done;
    bit          busy_ok;
    int          r;

    rst = 1'b1;
    bus.start = 1'b1; bus.flush = 1'b0; bus.funct3 = 3'b101; bus.op1 = 32'd5; bus.op2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "MUL", 1'b0, 1'b0, 1'b1);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH", 1'b0, 1'b0, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU", 1'b0, 1'b0, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, "MULHSU", 1'b0, 1'b0, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV", 1'b0, 1'b0, 1'b1);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "REM", 1'b0, 1'b0, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, "DIVU", 1'b0, 1'b0, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, "REMU", 1'b0, 1'b0, 1'b0);
    do_op(3'd5, 32'd5, 32'd0, "DIVU by zero", 1'b0, 1'b0, 1'b0);
    do_op(3'd6, 32'd5, 32'd0, "REM by zero", 1'b0, 1'b0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow", 1'b0, 1'b0, 1'b0);

    // flush together with start: special op would finish in cycle 1 if accepted
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b101; bus.op1 = 32'd9; bus.op2 = 32'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush+start done", 32'(bus.done), 32'd0);
    check("flush+start busy", 32'(bus.busy), 32'd0);
    check("flush+start result", bus.result, prev);

    // flush in cycle 10 of a running DIV
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b100; bus.op1 = 32'd1000; bus.op2 = 32'd3;
    @(posedge clk);
    busy_ok = 1'b1; seen_done = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done) seen_done = 1'b1;
      if (k <= 10 && !bus.busy) busy_ok = 1'b0;
      if (k == 10) bus.flush = 1'b1;
      if (k == 11) begin
        bus.flush = 1'b0;
        check("flush busy drop", 32'(bus.busy), 32'd0);
      end
    end
    check("flush busy before", 32'(busy_ok), 32'd1);
    check("flush no done", 32'(seen_done), 32'd0);
    check("flush result kept", bus.result, prev);
    do_op(3'd4, 32'hFFFF_FC18, 32'd3, "DIV after flush", 1'b0, 1'b0, 1'b0);

    // back-to-back: second start presented in the done cycle of the first
    do_op(3'd5, 32'd100, 32'd7, "b2b first", 1'b0, 1'b1, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, "b2b second", 1'b1, 1'b0, 1'b0);

    // reset in cycle 5 of RUN
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b100; bus.op1 = 32'h0123_4567; bus.op2 = 32'd13;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("rst aborted op no done", 32'(seen_done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 2) b = 32'($urandom_range(1, 20));
      do_op(f3, a, b, $sformatf("rand%0d f3=%0d", i, f3), 1'b0, 1'b0, r == 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
